// File: rtl/alu_op_driver.sv
// Command/response initiator for the 4-bit combinational ALU: registers operands onto the
// ALU, waits SETTLE_CYCLES, captures {OVF,C}. Define ALU_SELFCHECK_EN to add a result checker.
module alu_op_driver #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned WIDTH         = 4
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_c,
  output logic             rsp_ovf,
  output logic             rsp_err,
  output logic             err_sticky,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_ctrl0,
  output logic             alu_ctrl1,
  input  logic [WIDTH-1:0] alu_c,
  input  logic             alu_ovf,
  output logic             busy,
  output logic [7:0]       op_count
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_e;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

  state_e           state_q,      state_d;
  logic [3:0]       settle_cnt_q, settle_cnt_d;
  logic [WIDTH-1:0] alu_a_q,      alu_a_d;
  logic [WIDTH-1:0] alu_b_q,      alu_b_d;
  logic             alu_ctrl0_q,  alu_ctrl0_d;
  logic             alu_ctrl1_q,  alu_ctrl1_d;
  logic [WIDTH-1:0] rsp_c_q,      rsp_c_d;
  logic             rsp_ovf_q,    rsp_ovf_d;
  logic [7:0]       op_count_q,   op_count_d;

  // NOTE: every variable gets its hold value first, so no path through the case leaves
  // one unassigned and no latch can be inferred.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_ctrl0_d  = alu_ctrl0_q;
    alu_ctrl1_d  = alu_ctrl1_q;
    rsp_c_d      = rsp_c_q;
    rsp_ovf_d    = rsp_ovf_q;
    op_count_d   = op_count_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          alu_a_d      = cmd_a;
          alu_b_d      = cmd_b;
          alu_ctrl0_d  = cmd_op[0];
          alu_ctrl1_d  = cmd_op[1];
          settle_cnt_d = SETTLE_INIT;
          state_d      = S_SETTLE;
        end
      end
      S_SETTLE: begin
        // Counter reaching zero still costs one cycle here, so SETTLE lasts SETTLE_CYCLES+1.
        if (settle_cnt_q == 4'd0) state_d = S_CAPTURE;
        else                      settle_cnt_d = settle_cnt_q - 4'd1;
      end
      S_CAPTURE: begin
        rsp_c_d   = alu_c;
        rsp_ovf_d = alu_ovf;
        state_d   = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          op_count_d = op_count_q + 8'd1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q      <= S_IDLE;
      settle_cnt_q <= 4'd0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ctrl0_q  <= 1'b0;
      alu_ctrl1_q  <= 1'b0;
      rsp_c_q      <= '0;
      rsp_ovf_q    <= 1'b0;
      op_count_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_ctrl0_q  <= alu_ctrl0_d;
      alu_ctrl1_q  <= alu_ctrl1_d;
      rsp_c_q      <= rsp_c_d;
      rsp_ovf_q    <= rsp_ovf_d;
      op_count_q   <= op_count_d;
    end
  end

`ifdef ALU_SELFCHECK_EN
  logic [WIDTH:0] expected;
  logic           rsp_err_q,    rsp_err_d;
  logic           err_sticky_q, err_sticky_d;

  // Reference result from the operands currently held on the ALU inputs.
  always_comb begin
    expected = '0;
    unique case ({alu_ctrl1_q, alu_ctrl0_q})
      2'd0:    expected = {1'b0, alu_a_q} + {1'b0, alu_b_q};
      2'd1:    expected = {1'b0, alu_a_q} - {1'b0, alu_b_q};
      2'd2:    expected = {1'b0, alu_a_q & alu_b_q};
      default: expected[0] = (alu_a_q > alu_b_q);
    endcase
  end

  always_comb begin
    rsp_err_d    = rsp_err_q;
    err_sticky_d = err_sticky_q;
    if (state_q == S_CAPTURE) begin
      rsp_err_d    = ({alu_ovf, alu_c} != expected);
      err_sticky_d = err_sticky_q | rsp_err_d;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rsp_err_q    <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      rsp_err_q    <= rsp_err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign rsp_err    = rsp_err_q;
  assign err_sticky = err_sticky_q;
`else
  assign rsp_err    = 1'b0;
  assign err_sticky = 1'b0;
`endif

  // Handshake outputs depend on state only, never combinationally on the other side's signal.
  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_c     = rsp_c_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_ctrl0 = alu_ctrl0_q;
  assign alu_ctrl1 = alu_ctrl1_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_op_driver.sv
// Scoreboard bench for alu_op_driver: drives commands, models the ALU, and a negedge
// monitor compares every presented response against the queued expectation.
`timescale 1ns/1ps
module tb_alu_op_driver;

  localparam int W = 4;
  localparam int S = 1;
`ifdef ALU_SELFCHECK_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif

  logic         wb_clk_i = 1'b0;
  logic         wb_rst_i = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = 2'd0;
  logic [W-1:0] cmd_a = '0;
  logic [W-1:0] cmd_b = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_c;
  logic         rsp_ovf;
  logic         rsp_err;
  logic         err_sticky;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic         alu_ctrl0;
  logic         alu_ctrl1;
  logic [W-1:0] alu_c;
  logic         alu_ovf;
  logic         busy;
  logic [7:0]   op_count;

  alu_op_driver #(.SETTLE_CYCLES(S), .WIDTH(W)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_c(rsp_c),
    .rsp_ovf(rsp_ovf), .rsp_err(rsp_err), .err_sticky(err_sticky),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl0(alu_ctrl0), .alu_ctrl1(alu_ctrl1),
    .alu_c(alu_c), .alu_ovf(alu_ovf), .busy(busy), .op_count(op_count)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a, b, c;
    logic         ovf, err;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   sent = 0;
  bit   hold_rsp = 1'b0;
  bit   alu_fault = 1'b0;

  // ALU behaviour from its definition: {ovf,c} is the (W+1)-bit result.
  function automatic logic [W:0] alu_model(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    int ai = int'(a);
    int bi = int'(b);
    case (op)
      2'd0:    return (W+1)'(ai + bi);
      2'd1:    return (W+1)'(ai - bi);
      2'd2:    return (W+1)'(ai & bi);
      default: return (ai > bi) ? (W+1)'(1) : (W+1)'(0);
    endcase
  endfunction

  logic [W:0] alu_res;
  assign alu_res = alu_model({alu_ctrl1, alu_ctrl0}, alu_a, alu_b);
  assign alu_c   = alu_fault ? '0 : alu_res[W-1:0];
  assign alu_ovf = alu_res[W];

  always @(posedge wb_clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input bit fault);
    exp_t       e;
    logic [W:0] m;
    int         n = 0;
    @(negedge wb_clk_i);
    while (!cmd_ready && n < 200) begin
      @(negedge wb_clk_i);
      n++;
    end
    if (!cmd_ready) begin
      timeout("cmd_ready_wait");
      return;
    end
    m     = alu_model(op, a, b);
    e.op  = op;
    e.a   = a;
    e.b   = b;
    e.ovf = m[W];
    e.c   = fault ? '0 : m[W-1:0];
    e.err = SC && ({e.ovf, e.c} != m);
    e.acc = cyc + 1;
    sb.push_back(e);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    @(posedge wb_clk_i);
    #1 cmd_valid = 1'b0;
    sent++;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 500) begin
      @(negedge wb_clk_i);
      n++;
    end
    if (sb.size() != 0 || busy) timeout("drain");
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_zeros"}, 32'({rsp_valid, rsp_c, rsp_ovf, rsp_err, err_sticky, alu_a,
                                alu_b, alu_ctrl0, alu_ctrl1, busy, op_count}), 32'd0);
  endtask

  initial begin
    forever begin
      @(posedge wb_clk_i);
      #1 rsp_ready = hold_rsp ? 1'b0 : ($urandom_range(3) != 0);
    end
  end

  // Response monitor: decoupled from stimulus, driven purely by what the DUT presents.
  int   cnt_m = 0;
  bit   sticky_m = 1'b0;
  bit   seen_valid = 1'b0;
  exp_t e_m;
  always @(negedge wb_clk_i) begin
    if (wb_rst_i) begin
      cnt_m      = 0;
      sticky_m   = 1'b0;
      seen_valid = 1'b0;
    end else begin
      check("op_count", 32'(op_count), 32'(cnt_m % 256));
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp_valid", 32'(rsp_valid), 32'd0);
        end else begin
          e_m = sb[0];
          if (!seen_valid) begin
            check("latency", 32'(cyc - e_m.acc), 32'(S + 2));
            sticky_m   = sticky_m | e_m.err;
            seen_valid = 1'b1;
          end
          check("rsp_c", 32'(rsp_c), 32'(e_m.c));
          check("rsp_ovf", 32'(rsp_ovf), 32'(e_m.ovf));
          check("rsp_err", 32'(rsp_err), 32'(e_m.err));
          check("err_sticky", 32'(err_sticky), 32'(sticky_m));
          check("cmd_ready_in_resp", 32'(cmd_ready), 32'd0);
          check("busy_in_resp", 32'(busy), 32'd1);
          check("alu_operands", 32'({alu_a, alu_b}), 32'({e_m.a, e_m.b}));
          check("alu_ctrl", 32'({alu_ctrl1, alu_ctrl0}), 32'(e_m.op));
          if (rsp_ready) begin
            void'(sb.pop_front());
            cnt_m++;
            seen_valid = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(posedge wb_clk_i);
    #1 check_reset_outputs("reset_init");
    @(negedge wb_clk_i) wb_rst_i = 1'b0;

    // Directed ALU cases.
    send(2'd0, 4'd9, 4'd8, 1'b0);
    send(2'd1, 4'd3, 4'd5, 1'b0);
    send(2'd2, 4'hC, 4'hA, 1'b0);
    send(2'd3, 4'd7, 4'd3, 1'b0);
    send(2'd3, 4'd3, 4'd7, 1'b0);
    send(2'd0, 4'hF, 4'hF, 1'b0);
    send(2'd1, 4'd0, 4'd0, 1'b0);
    wait_done();

    // Response held back: outputs stay put and a pending command is ignored.
    hold_rsp = 1'b1;
    @(posedge wb_clk_i);
    #2 send(2'd1, 4'd2, 4'd9, 1'b0);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(posedge wb_clk_i);
      n++;
    end
    if (!rsp_valid) timeout("stall_rsp_valid");
    #1;
    cmd_valid = 1'b1;
    cmd_op    = 2'd0;
    cmd_a     = 4'd5;
    cmd_b     = 4'd6;
    repeat (5) @(posedge wb_clk_i);
    #1 cmd_valid = 1'b0;
    check("stall_rsp_valid_held", 32'(rsp_valid), 32'd1);
    hold_rsp = 1'b0;
    wait_done();

    // Random traffic, enough to wrap op_count past 255.
    for (int i = 0; i < 260; i++)
      send(2'($urandom_range(3)), 4'($urandom_range(15)), 4'($urandom_range(15)), 1'b0);
    wait_done();
    check("op_count_wrap", 32'(op_count), 32'(sent % 256));

    // Broken ALU result: checker flags it when built in.
    alu_fault = 1'b1;
    send(2'd0, 4'd2, 4'd2, 1'b1);
    wait_done();
    alu_fault = 1'b0;
    send(2'd2, 4'd6, 4'd3, 1'b0);
    wait_done();
    check("err_sticky_holds", 32'(err_sticky), 32'(SC));

    // Asynchronous reset while the op is settling.
    send(2'd0, 4'd1, 4'd1, 1'b0);
    #2 wb_rst_i = 1'b1;
    #1 check_reset_outputs("reset_in_settle");
    sb.delete();
    sent = 0;
    @(negedge wb_clk_i);
    @(negedge wb_clk_i) wb_rst_i = 1'b0;
    repeat (8) @(posedge wb_clk_i);
    #1 check("no_rsp_after_reset", 32'({rsp_valid, busy}), 32'd0);
    send(2'd1, 4'd8, 4'd1, 1'b0);
    wait_done();
    check("recover_count", 32'(op_count), 32'd1);

    repeat (2) @(posedge wb_clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
